// File: rtl/dma_byp_pkg.sv
// rtl/dma_byp_pkg.sv - shared widths, entry/state types and helpers for the bypass-out sink
package dma_byp_pkg;
  localparam int DSC_W  = 256;
  localparam int CIDX_W = 16;

  typedef struct packed {
    logic [CIDX_W-1:0] cidx;
    logic [DSC_W-1:0]  dsc;
  } byp_out_entry_t;

  typedef enum logic {UPD_IDLE, UPD_PEND} upd_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/dma_byp_sync_fifo.sv
// rtl/dma_byp_sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty/count
// Head entry is combinationally visible on rd_data whenever empty is low.
module dma_byp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/dma_byp_out_sink.sv
// rtl/dma_byp_out_sink.sv - bypass-out descriptor sink: buffer, cidx sequence check, coalesced cidx write-back
// Optional DMA_BYP_OUT_STATS_EN adds accepted-beat and ingress-stall counters.
module dma_byp_out_sink import dma_byp_pkg::*; #(
  parameter int FIFO_DEPTH     = 8,
  parameter int CIDX_UPD_INTVL = 4,
  parameter int CIDX_TIMEOUT   = 64
) (
  input  logic          user_clk,
  input  logic          user_reset_n,
  input  logic [255:0]  byp_dsc,
  input  logic [15:0]   byp_cidx,
  input  logic          byp_vld,
  output logic          byp_rdy,
  output logic [255:0]  out_dsc,
  output logic [15:0]   out_cidx,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [15:0]   cidx_upd,
  output logic          cidx_upd_vld,
  input  logic          cidx_upd_rdy,
  output logic          err_seq,
  output logic [7:0]    err_cnt
`ifdef DMA_BYP_OUT_STATS_EN
  ,
  output logic [31:0]   stat_dsc_cnt,
  output logic [31:0]   stat_stall_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH + CIDX_UPD_INTVL + 1);
  localparam int TW = $clog2(CIDX_TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PCNT_MAX = PW'(FIFO_DEPTH + CIDX_UPD_INTVL);
  localparam logic [PW-1:0] INTVL_C  = PW'(CIDX_UPD_INTVL);
  localparam logic [TW-1:0] TMO_C    = TW'(CIDX_TIMEOUT);

  byp_out_entry_t wr_entry, head, last_q;
  logic           push, pop, full, empty;
  logic [AW:0]    count, count_nxt;

  assign wr_entry = '{cidx: byp_cidx, dsc: byp_dsc};
  assign push     = byp_vld & byp_rdy & ~full;
  assign out_vld  = ~empty;
  assign pop      = out_vld & out_rdy;
  // When empty the outputs hold the most recently popped entry.
  assign out_dsc  = empty ? last_q.dsc  : head.dsc;
  assign out_cidx = empty ? last_q.cidx : head.cidx;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  dma_byp_sync_fifo #(.WIDTH($bits(byp_out_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (user_clk),
    .rst_n   (user_reset_n),
    .wr_data (wr_entry),
    .wr_en   (push),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      byp_rdy <= 1'b0;
      last_q  <= '0;
    end else begin
      byp_rdy <= (count_nxt < DEPTH_C);
      if (pop) last_q <= head;
    end
  end

  logic        seen;
  logic [15:0] exp_cidx;

  // Mismatches resync the expectation so one gap counts once.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      seen     <= 1'b0;
      exp_cidx <= '0;
      err_seq  <= 1'b0;
      err_cnt  <= '0;
    end else if (push) begin
      seen     <= 1'b1;
      exp_cidx <= byp_cidx + 16'd1;
      if (seen && byp_cidx != exp_cidx) begin
        err_seq <= 1'b1;
        err_cnt <= sat_inc8(err_cnt);
      end
    end
  end

  upd_state_e    state_q, state_d;
  logic [PW-1:0] pcnt, pcnt_sat;
  logic [TW-1:0] tmr;
  logic [15:0]   last_pop_cidx;
  logic          trigger;

  assign pcnt_sat = (pop && pcnt != PCNT_MAX) ? pcnt + 1'b1 : pcnt;
  assign trigger  = (state_q == UPD_IDLE) && (pcnt_sat >= INTVL_C || tmr == TMO_C);

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) state_q <= UPD_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UPD_IDLE: if (trigger)      state_d = UPD_PEND;
      UPD_PEND: if (cidx_upd_rdy) state_d = UPD_IDLE;
      default:                    state_d = UPD_IDLE;
    endcase
  end

  always_comb begin
    cidx_upd_vld = (state_q == UPD_PEND);
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      pcnt          <= '0;
      tmr           <= '0;
      last_pop_cidx <= '0;
      cidx_upd      <= '0;
    end else begin
      if (pop) last_pop_cidx <= head.cidx;
      if (trigger) begin
        pcnt     <= '0;
        tmr      <= '0;
        cidx_upd <= pop ? head.cidx : last_pop_cidx;
      end else begin
        pcnt <= pcnt_sat;
        if (pop)                             tmr <= '0;
        else if (pcnt != '0 && tmr != TMO_C) tmr <= tmr + 1'b1;
      end
    end
  end

`ifdef DMA_BYP_OUT_STATS_EN
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      stat_dsc_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      stat_dsc_cnt   <= stat_dsc_cnt + 32'(push);
      stat_stall_cnt <= stat_stall_cnt + 32'(byp_vld & ~byp_rdy);
    end
  end
`endif
endmodule

// File: tb/tb_dma_byp_out_sink.sv
// tb/tb_dma_byp_out_sink.sv - directed scoreboard bench for dma_byp_out_sink
module tb_dma_byp_out_sink;
  logic         user_clk = 1'b0;
  logic         user_reset_n = 1'b0;
  logic [255:0] byp_dsc = '0;
  logic [15:0]  byp_cidx = '0;
  logic         byp_vld = 1'b0;
  logic         byp_rdy;
  logic [255:0] out_dsc;
  logic [15:0]  out_cidx;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic [15:0]  cidx_upd;
  logic         cidx_upd_vld;
  logic         cidx_upd_rdy = 1'b1;
  logic         err_seq;
  logic [7:0]   err_cnt;
`ifdef DMA_BYP_OUT_STATS_EN
  logic [31:0]  stat_dsc_cnt, stat_stall_cnt;
`endif

  dma_byp_out_sink dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .byp_dsc(byp_dsc), .byp_cidx(byp_cidx), .byp_vld(byp_vld), .byp_rdy(byp_rdy),
    .out_dsc(out_dsc), .out_cidx(out_cidx), .out_vld(out_vld), .out_rdy(out_rdy),
    .cidx_upd(cidx_upd), .cidx_upd_vld(cidx_upd_vld), .cidx_upd_rdy(cidx_upd_rdy),
    .err_seq(err_seq), .err_cnt(err_cnt)
`ifdef DMA_BYP_OUT_STATS_EN
    , .stat_dsc_cnt(stat_dsc_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [15:0]  c;
    logic [255:0] d;
  } ent_t;

  ent_t sb[$];
  int checks = 0;
  int failures = 0;
  int stall_model = 0;
  int pop_model = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Handshakes are sampled mid-cycle; pop is compared before the same-cycle push is queued.
  always @(negedge user_clk) begin
    if (out_vld && out_rdy) begin
      chk("pop_has_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        ent_t e;
        e = sb.pop_front();
        chk("pop_cidx", 256'(out_cidx), 256'(e.c));
        chk("pop_dsc", out_dsc, e.d);
      end
      pop_model++;
    end
    if (byp_vld && byp_rdy) sb.push_back('{byp_cidx, byp_dsc});
    if (byp_vld && !byp_rdy) stall_model++;
  end

  task automatic step(output bit acc);
    @(negedge user_clk);
    acc = byp_vld && byp_rdy;
    @(posedge user_clk);
    #1;
  endtask

  task automatic tick(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic offer(input logic [15:0] c);
    bit acc;
    byp_cidx = c;
    byp_dsc  = rnd256();
    byp_vld  = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) step(acc);
    byp_vld = 1'b0;
    chk("offer_accepted", 256'(acc), 256'(1));
  endtask

  task automatic wait_upd(input int bound, output int n);
    bit a;
    n = 0;
    do begin
      step(a);
      n++;
    end while (!cidx_upd_vld && n < bound);
    chk("upd_seen", 256'(cidx_upd_vld), 256'(1));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_byp_rdy"}, 256'(byp_rdy), 256'(0));
    chk({tag, "_out_vld"}, 256'(out_vld), 256'(0));
    chk({tag, "_out_dsc"}, out_dsc, 256'(0));
    chk({tag, "_out_cidx"}, 256'(out_cidx), 256'(0));
    chk({tag, "_upd"}, 256'(cidx_upd), 256'(0));
    chk({tag, "_upd_vld"}, 256'(cidx_upd_vld), 256'(0));
    chk({tag, "_err_seq"}, 256'(err_seq), 256'(0));
    chk({tag, "_err_cnt"}, 256'(err_cnt), 256'(0));
  endtask

  task automatic do_reset();
    byp_vld = 1'b0;
    user_reset_n = 1'b0;
    repeat (2) @(posedge user_clk);
    sb.delete();
    stall_model = 0;
    pop_model = 0;
    #1;
    user_reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int n, nacc;

    // 1: reset state, FWFT latency, timeout-driven update
    repeat (2) @(posedge user_clk);
    #1;
    check_zero_outputs("t1_reset");
    user_reset_n = 1'b1;
    chk("t1_rdy_before_edge", 256'(byp_rdy), 256'(0));
    tick(1);
    chk("t1_rdy_after_edge", 256'(byp_rdy), 256'(1));
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(16'(i));
      chk("t1_out_vld_latency", 256'(out_vld), 256'(1));
      chk("t1_out_cidx_latency", 256'(out_cidx), 256'(i));
    end
    // last pop one edge later, then 64 idle increments, then one edge into PEND
    wait_upd(200, n);
    chk("t1_timeout_cycles", 256'(n), 256'(66));
    chk("t1_upd_cidx", 256'(cidx_upd), 256'(2));
    chk("t1_err_seq", 256'(err_seq), 256'(0));

    // 2: fill to full, one pop frees one slot, ninth beat accepted
    do_reset();
    tick(1);
    out_rdy = 1'b0;
    nacc = 0;
    byp_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      byp_cidx = 16'(nacc);
      byp_dsc  = rnd256();
      step(a);
      if (a) nacc++;
    end
    chk("t2_accepted", 256'(nacc), 256'(8));
    chk("t2_full_rdy", 256'(byp_rdy), 256'(0));
    chk("t2_head_cidx", 256'(out_cidx), 256'(0));
    out_rdy = 1'b1;
    byp_cidx = 16'd8;
    step(a);
    out_rdy = 1'b0;
    chk("t2_no_accept_full", 256'(a), 256'(0));
    chk("t2_rdy_after_pop", 256'(byp_rdy), 256'(1));
    step(a);
    byp_vld = 1'b0;
    chk("t2_ninth_accepted", 256'(a), 256'(1));
`ifdef DMA_BYP_OUT_STATS_EN
    chk("t7_stat_dsc", 256'(stat_dsc_cnt), 256'(9));
    chk("t7_stat_stall", 256'(stat_stall_cnt), 256'(stall_model));
`endif
    out_rdy = 1'b1;
    tick(10);
    chk("t2_drained", 256'(out_vld), 256'(0));
    chk("t2_pop_count", 256'(pop_model), 256'(9));
    chk("t2_sb_empty", 256'(sb.size()), 256'(0));
    chk("t2_out_holds_last", 256'(out_cidx), 256'(8));

    // 3: gap in sequence flagged once
    do_reset();
    out_rdy = 1'b1;
    offer(16'd5);
    offer(16'd6);
    chk("t3_no_err_yet", 256'(err_seq), 256'(0));
    offer(16'd9);
    chk("t3_err_on_gap", 256'(err_seq), 256'(1));
    offer(16'd10);
    chk("t3_err_seq", 256'(err_seq), 256'(1));
    chk("t3_err_cnt", 256'(err_cnt), 256'(1));

    // 4: 16-bit wrap is in sequence
    do_reset();
    offer(16'hFFFE);
    offer(16'hFFFF);
    offer(16'h0000);
    offer(16'h0001);
    chk("t4_err_seq", 256'(err_seq), 256'(0));
    chk("t4_err_cnt", 256'(err_cnt), 256'(0));

    // error counter saturation: 299 repeated cidx values after the unchecked first
    do_reset();
    for (int i = 0; i < 300; i++) offer(16'd0);
    chk("sat_err_cnt", 256'(err_cnt), 256'(255));
    chk("sat_err_seq", 256'(err_seq), 256'(1));

    // 5: interval update held while not accepted, second update after release
    cidx_upd_rdy = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) offer(16'(100 + i));
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_vld", 256'(cidx_upd_vld), 256'(1));
      chk("t5_hold_cidx", 256'(cidx_upd), 256'(103));
      tick(1);
    end
    chk("t5_pops", 256'(pop_model), 256'(8));
    cidx_upd_rdy = 1'b1;
    tick(1);
    chk("t5_idle_gap", 256'(cidx_upd_vld), 256'(0));
    tick(1);
    chk("t5_second_vld", 256'(cidx_upd_vld), 256'(1));
    chk("t5_second_cidx", 256'(cidx_upd), 256'(107));

    // 6: asynchronous reset with queued entries and a pending update
    cidx_upd_rdy = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) offer(16'(200 + i));
    tick(1);
    out_rdy = 1'b0;
    for (int i = 4; i < 9; i++) offer(16'(200 + i));
    chk("t6_pend_before", 256'(cidx_upd_vld), 256'(1));
    chk("t6_queued_before", 256'(out_vld), 256'(1));
    #2;
    user_reset_n = 1'b0;
    #1;
    check_zero_outputs("t6_async");
    do_reset();
    cidx_upd_rdy = 1'b1;
    chk("t6_empty_after", 256'(out_vld), 256'(0));
    out_rdy = 1'b1;
    tick(1);
    offer(16'h1234);
    offer(16'h1235);
    tick(2);
    chk("t6_first_unchecked", 256'(err_seq), 256'(0));
    chk("t6_sb_empty", 256'(sb.size()), 256'(0));
    chk("t6_pops", 256'(pop_model), 256'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
